// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: md_op encoding, default latencies and the
// two-state view of the iteration counter.
package md_pkg;

    typedef enum logic [3:0] {
        MdNone  = 4'd0,
        MdMult  = 4'd1,
        MdMultu = 4'd2,
        MdDiv   = 4'd3,
        MdDivu  = 4'd4,
        MdMthi  = 4'd5,
        MdMtlo  = 4'd6
    } mdOpE;

    typedef enum logic {
        StIdle,
        StRun
    } mdStateE;

    localparam int unsigned MulLatDefault = 5;
    localparam int unsigned DivLatDefault = 10;

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit signed/unsigned divider producing quotient, remainder
// and a zero-divisor flag.
module mdu_div_core (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        isSigned,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divZero
);

    logic        negA;
    logic        negB;
    logic        intMinCase;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] safeB;
    logic [31:0] magQ;
    logic [31:0] magR;

    always_comb begin
        divZero    = (divisor == 32'd0);
        intMinCase = isSigned && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        negA       = isSigned & dividend[31];
        negB       = isSigned & divisor[31];
        magA       = negA ? (32'd0 - dividend) : dividend;
        magB       = negB ? (32'd0 - divisor) : divisor;
        // Keep the divide well defined; the result is discarded when divZero is set.
        safeB      = divZero ? 32'd1 : magB;
        magQ       = magA / safeB;
        magR       = magA % safeB;
        quotient   = (negA ^ negB) ? (32'd0 - magQ) : magQ;
        remainder  = negA ? (32'd0 - magR) : magR;
        if (divZero) begin
            quotient  = 32'd0;
            remainder = 32'd0;
        end else if (intMinCase) begin
            quotient  = 32'h8000_0000;
            remainder = 32'd0;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MIPS HI/LO unit: results are computed at issue, held in pending
// registers and committed to HI/LO when the latency counter expires.
module mdu_iter
    import md_pkg::*;
#(
    parameter int unsigned MUL_LAT = MulLatDefault,
    parameter int unsigned DIV_LAT = DivLatDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [CntW-1:0] cntQ, cntD;
    logic [31:0]     hiQ, hiD, loQ, loD;
    logic [31:0]     pendHiQ, pendHiD, pendLoQ, pendLoD;
    logic            pendWrQ, pendWrD;
    mdStateE         state;

    logic        opMul, opDiv, opSigned, opMthi, opMtlo;
    logic [63:0] mulA, mulB, prod;
    logic [31:0] quot, rem;
    logic        divZero;

    always_comb begin
        opMul    = 1'b0;
        opDiv    = 1'b0;
        opSigned = 1'b0;
        opMthi   = 1'b0;
        opMtlo   = 1'b0;
        case (md_op)
            MdMult:  begin opMul = 1'b1; opSigned = 1'b1; end
            MdMultu: opMul = 1'b1;
            MdDiv:   begin opDiv = 1'b1; opSigned = 1'b1; end
            MdDivu:  opDiv = 1'b1;
            MdMthi:  opMthi = 1'b1;
            MdMtlo:  opMtlo = 1'b1;
            default: ;
        endcase
    end

    // Low 64 bits of a 64x64 product of extended operands serve both signednesses.
    always_comb begin
        mulA = opSigned ? {{32{rs[31]}}, rs} : {32'd0, rs};
        mulB = opSigned ? {{32{rt[31]}}, rt} : {32'd0, rt};
        prod = mulA * mulB;
    end

    mdu_div_core uDivCore (
        .dividend  (rs),
        .divisor   (rt),
        .isSigned  (opSigned),
        .quotient  (quot),
        .remainder (rem),
        .divZero   (divZero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cntQ    <= '0;
            hiQ     <= 32'd0;
            loQ     <= 32'd0;
            pendHiQ <= 32'd0;
            pendLoQ <= 32'd0;
            pendWrQ <= 1'b0;
        end else begin
            cntQ    <= cntD;
            hiQ     <= hiD;
            loQ     <= loD;
            pendHiQ <= pendHiD;
            pendLoQ <= pendLoD;
            pendWrQ <= pendWrD;
        end
    end

    always_comb begin
        cntD    = cntQ;
        hiD     = hiQ;
        loD     = loQ;
        pendHiD = pendHiQ;
        pendLoD = pendLoQ;
        pendWrD = pendWrQ;
        unique case (state)
            StRun: begin
                cntD = cntQ - CntW'(1);
                if (cntQ == CntW'(1) && pendWrQ) begin
                    hiD = pendHiQ;
                    loD = pendLoQ;
                end
            end
            StIdle: begin
                if (opMul) begin
                    pendHiD = prod[63:32];
                    pendLoD = prod[31:0];
                    pendWrD = 1'b1;
                    cntD    = CntW'(MUL_LAT);
                end else if (opDiv) begin
                    pendHiD = rem;
                    pendLoD = quot;
                    pendWrD = !divZero;
                    cntD    = CntW'(DIV_LAT);
                end else if (opMthi) begin
                    hiD = rs;
                end else if (opMtlo) begin
                    loD = rs;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (cntQ != '0);
        state = busy ? StRun : StIdle;
        start = (opMul || opDiv) && !busy;
        hi    = hiQ;
        lo    = loQ;
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: multiply/divide latency windows, HI/LO results,
// MT writes, busy protection and reset abort.
module tb_mdu_iter;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs, rt;
    logic        start, busy;
    logic [31:0] hi, lo;

    int nCompared   = 0;
    int nMismatched = 0;

    mdu_iter #(
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md_op (md_op),
        .rs    (rs),
        .rt    (rt),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue an op at the current cycle, then walk the busy window checking hi/lo hold.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] preHi, input logic [31:0] preLo);
        md_op = op;
        rs    = a;
        rt    = b;
        @(negedge clk);
        checkVal({tag, " start"}, 64'(start), 64'd1);
        checkVal({tag, " busy@T"}, 64'(busy), 64'd0);
        checkVal({tag, " hi@T"}, 64'(hi), 64'(preHi));
        checkVal({tag, " lo@T"}, 64'(lo), 64'(preLo));
        nextCycle();
        md_op = MdNone;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            checkVal($sformatf("%s busy@T+%0d", tag, k), 64'(busy), 64'd1);
            checkVal($sformatf("%s hold@T+%0d", tag, k), {hi, lo}, {preHi, preLo});
            nextCycle();
        end
    endtask

    task automatic checkDone(input string tag, input logic [31:0] expHi,
                             input logic [31:0] expLo);
        @(negedge clk);
        checkVal({tag, " busy done"}, 64'(busy), 64'd0);
        checkVal({tag, " hi"}, 64'(hi), 64'(expHi));
        checkVal({tag, " lo"}, 64'(lo), 64'(expLo));
        nextCycle();
    endtask

    initial begin
        reset = 1'b1;
        md_op = MdMult;
        rs    = 32'd5;
        rt    = 32'd5;
        @(negedge clk);
        checkVal("start in reset", 64'(start), 64'd1);
        nextCycle();
        reset = 1'b0;
        md_op = MdNone;
        @(negedge clk);
        checkVal("reset busy", 64'(busy), 64'd0);
        checkVal("reset hi/lo", {hi, lo}, 64'd0);
        nextCycle();

        // MTHI with busy low
        md_op = MdMthi;
        rs    = 32'h1234;
        @(negedge clk);
        checkVal("mthi start", 64'(start), 64'd0);
        nextCycle();
        md_op = MdNone;
        @(negedge clk);
        checkVal("mthi hi", 64'(hi), 64'h1234);
        checkVal("mthi busy", 64'(busy), 64'd0);
        nextCycle();

        runOp("mult", MdMult, 32'hFFFF_FFFE, 32'd3, 5, 32'h1234, 32'd0);
        checkDone("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        runOp("multu", MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        checkDone("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        runOp("div", MdDiv, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFE, 32'h0000_0001);
        checkDone("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        runOp("divu0", MdDivu, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        checkDone("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        runOp("divmin", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        checkDone("divmin", 32'd0, 32'h8000_0000);

        // Back-to-back: second MULT issued in the cycle busy falls
        runOp("b2b1", MdMult, 32'd7, 32'd6, 5, 32'd0, 32'h8000_0000);
        runOp("b2b2", MdMult, 32'hFFFF_FFFF, 32'd5, 5, 32'd0, 32'd42);
        checkDone("b2b2", 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Ops presented while busy must be ignored, including MTHI on the commit edge
        md_op = MdMult;
        rs    = 32'd3;
        rt    = 32'd4;
        @(negedge clk);
        checkVal("prot start", 64'(start), 64'd1);
        nextCycle();
        for (int k = 1; k <= 5; k++) begin
            case (k)
                2:       begin md_op = MdMult; rs = 32'd9; rt = 32'd9; end
                3:       begin md_op = MdMtlo; rs = 32'hDEAD; end
                5:       begin md_op = MdMthi; rs = 32'hBEEF; end
                default: md_op = MdNone;
            endcase
            @(negedge clk);
            checkVal($sformatf("prot start@T+%0d", k), 64'(start), 64'd0);
            checkVal($sformatf("prot hold@T+%0d", k), {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
            nextCycle();
        end
        md_op = MdNone;
        checkDone("prot", 32'd0, 32'd12);

        // Reset at T+4 of a DIV aborts it
        md_op = MdDiv;
        rs    = 32'd100;
        rt    = 32'd7;
        nextCycle();
        md_op = MdNone;
        repeat (3) nextCycle();
        reset = 1'b1;
        md_op = MdMthi;
        rs    = 32'h5555;
        nextCycle();
        reset = 1'b0;
        md_op = MdNone;
        @(negedge clk);
        checkVal("abort busy", 64'(busy), 64'd0);
        checkVal("abort hi/lo", {hi, lo}, 64'd0);
        repeat (12) nextCycle();
        @(negedge clk);
        checkVal("abort no commit", {hi, lo}, 64'd0);
        checkVal("abort busy late", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port md_op  input  4  operation in EX this cycle: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7-15 are treated as NONE.
REQ-004 SHALL have port rs  input  32  forwarded rs operand from EX.
REQ-005 SHALL have port rt  input  32  forwarded rt/ALU-mux operand from EX.
REQ-006 SHALL have port start  output  1  combinational; high when md_op is MULT/MULTU/DIV/DIVU and busy is low.
REQ-007 SHALL have port busy  output  1  registered; high while a multiply or divide is in flight.
REQ-008 SHALL have port hi  output  32  architectural HI register; MFHI reads it combinationally.
REQ-009 SHALL have port lo  output  32  architectural LO register; MFLO reads it combinationally.
REQ-010 SHALL have parameter MUL_LAT, default 5, meaning busy cycles for MULT/MULTU.
REQ-011 SHALL have parameter DIV_LAT, default 10, meaning busy cycles for DIV/DIVU.

Function
REQ-012 SHALL, at the edge ending a start cycle T, compute the result from rs/rt and hold it in pending registers.
REQ-013 SHALL, at that same edge, load the down-counter with MUL_LAT or DIV_LAT.
REQ-014 SHALL drive busy = (counter != 0), so busy is high in cycles T+1..T+LAT.
REQ-015 SHALL decrement the counter each edge while it is nonzero.
REQ-016 SHALL commit pending hi/lo into hi/lo on the edge where the counter goes 1->0; new values are visible and busy is low from cycle T+LAT+1.
REQ-017 SHALL compute MULT as the signed 64-bit product and MULTU as the unsigned 64-bit product; hi = bits 63:32, lo = bits 31:0.
REQ-018 SHALL compute DIV/DIVU as lo = quotient, hi = remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-019 SHALL return lo=0x80000000, hi=0 for DIV of 0x80000000 by 0xFFFFFFFF.
REQ-020 SHALL leave hi and lo unchanged at commit when the divisor is 0 (DIV/DIVU), while still asserting busy for DIV_LAT cycles.
REQ-021 SHALL write rs into hi (MTHI) or lo (MTLO) at the end of the same cycle, with no busy, when busy is low.
REQ-022 SHALL ignore any MULT/MULTU/DIV/DIVU/MTHI/MTLO presented while busy is high: no state change and start stays low. Upstream stalls on start|busy, so this is a protection case only.
REQ-023 SHALL keep hi/lo stable during busy; MFHI/MFLO during busy return the pre-operation values (hazard logic stalls these).
REQ-024 SHALL, for MTHI/MTLO on the commit edge (counter==1, busy high), ignore the MT per REQ-022; the commit proceeds.
REQ-025 SHALL have a state machine IDLE (counter==0) -> RUN (counter>0) on start -> IDLE after LAT cycles; no other states.

Reset
REQ-026 SHALL, while reset is high at an edge, clear hi, lo, pending registers and the counter to 0 (busy=0).
REQ-027 SHALL abort an in-flight operation on reset with no commit, and give reset priority over start and MT writes.
REQ-028 SHALL gate start with busy only; start is high in the reset cycle if md_op requests one, but nothing is latched.

Structure
REQ-029 SHALL take the md_op encoding and the MUL_LAT/DIV_LAT defaults from shared package md_pkg, which the decoder also uses.
REQ-030 SHALL place signed/unsigned divide with the zero-divisor flag and the INT_MIN/-1 case in one sub-module, mdu_div_core (combinational); the counter, pending registers and hi/lo stay in mdu_iter.

Verification
REQ-031 SHALL cover: MULT rs=0xFFFFFFFE, rt=3 -> start=1 at T, busy T+1..T+5, at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
REQ-032 SHALL cover: MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> at T+6 hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL cover: DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, at T+11 lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 busy cycles.
REQ-034 SHALL cover: MTHI rs=0x1234 with busy low -> hi=0x1234 next cycle, busy stays 0; MTLO issued at T+3 of a MULT -> ignored, lo = product at T+6.
REQ-035 SHALL cover: reset asserted at T+4 of a DIV -> next cycle busy=0, hi=lo=0, no later commit.
REQ-036 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; back-to-back MULT issued the cycle busy falls -> start=1 and a new 5-cycle busy window.
